// File: rtl/arrow_spawner.sv
// -----------------------------------------------------------------------------
// arrow_spawner
//
// Upstream sequencer for the arrow stage. It decides when each arrow launches,
// and with which direction, speed and trajectory. It consumes the arrow's
// resolution (is_hit / hit_player) and keeps score, lives and the game-over
// flag. Only one arrow is in flight at a time.
//
// Ports
//   clk            in   1   system clock (pixel clock domain)
//   rst            in   1   synchronous, active-high reset
//   hcount_in      in  11   raster horizontal count
//   vcount_in      in  10   raster vertical count
//   start_in       in   1   start/restart request, level, sampled each cycle
//   is_hit_in      in   1   arrow resolved (blocked or hit the player)
//   hit_player_in  in   1   arrow struck the player (pulse)
//   valid_out      out  1   arrow active; its rising edge launches the arrow
//   direction_out  out  2   00 top, 01 bottom, 10 left, 11 right
//   speed_out      out  3   speed level 1..7
//   inversed_out   out  1   parabolic/inversed trajectory request
//   score_out      out  8   blocked-arrow count, saturating at 255
//   lives_out      out  3   remaining lives
//   game_over_out  out  1   high while the game is over
//
// Configuration macro
//   ARROW_FIXED_SEQ_EN  when defined, directions cycle 00,01,10,11,... in
//                       launch order and inversed_out is always 0. The LFSR
//                       keeps running but is not used. When undefined,
//                       direction and inversed come from the LFSR.
// -----------------------------------------------------------------------------
module arrow_spawner #(
  parameter int unsigned SPAWN_GAP = 60,       // initial gap in frames (<=255)
  parameter int unsigned MIN_GAP   = 20,       // gap floor as difficulty rises
  parameter int unsigned LIVES     = 3,        // lives at start (1..7)
  parameter int unsigned FLY_MAX   = 255,      // frame timeout of one flight
  parameter logic [15:0] LFSR_SEED = 16'hACE1  // must be nonzero
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        start_in,
  input  logic        is_hit_in,
  input  logic        hit_player_in,
  output logic        valid_out,
  output logic [1:0]  direction_out,
  output logic [2:0]  speed_out,
  output logic        inversed_out,
  output logic [7:0]  score_out,
  output logic [2:0]  lives_out,
  output logic        game_over_out
);

  localparam int unsigned GAP_W     = 8;
  localparam int unsigned FLY_W     = $clog2(FLY_MAX + 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GAP    = 3'd1,
    ST_FLY    = 3'd2,
    ST_SETTLE = 3'd3,
    ST_OVER   = 3'd4
  } state_e;

  // Registered state and outputs
  state_e             state_q;
  logic [15:0]        lfsr_q;
  logic [GAP_W-1:0]   gap_q;        // current spawn gap (shrinks with score)
  logic [GAP_W-1:0]   gap_cnt_q;    // frames left before the next launch
  logic [FLY_W-1:0]   fly_cnt_q;    // frames spent in the current flight
  logic [1:0]         fly_age_q;    // cycles in FLY, saturating at 2
  logic               settle_q;     // 0 = first SETTLE cycle, 1 = exit cycle
  logic               miss_q;       // hit_player seen during resolution
  logic               valid_q;
  logic [1:0]         dir_q;
  logic [2:0]         speed_q;
  logic               inv_q;
  logic [7:0]         score_q;
  logic [2:0]         lives_q;
  logic               over_q;
`ifdef ARROW_FIXED_SEQ_EN
  logic [1:0]         seq_q;        // launch index modulo 4
`endif

  // Next-state helpers
  logic               frame_tick;
  logic [15:0]        lfsr_d;
  logic [1:0]         launch_dir_d;
  logic               launch_inv_d;
  logic [2:0]         launch_speed_d;
  logic [7:0]         score_inc_d;
  logic [GAP_W-1:0]   gap_dn_d;
  logic [GAP_W-1:0]   gap_block_d;
  logic               miss_d;

  // Frame tick, LFSR step, launch attributes and scoring arithmetic
  always_comb begin
    frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    // Galois step: shift right, fold the mask in when a 1 falls out
    if (lfsr_q[0]) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ LFSR_MASK;
    end else begin
      lfsr_d = {1'b0, lfsr_q[15:1]};
    end

`ifdef ARROW_FIXED_SEQ_EN
    launch_dir_d = seq_q;
    launch_inv_d = 1'b0;
`else
    launch_dir_d = lfsr_q[1:0];
    // Only vertical directions (top/bottom) may fly inversed
    launch_inv_d = lfsr_q[2] & ~lfsr_q[1];
`endif

    // speed = 1 + score/8, capped at 7; below the cap score[7:6] is zero
    if (score_q[7:3] >= 5'd6) begin
      launch_speed_d = 3'd7;
    end else begin
      launch_speed_d = score_q[5:3] + 3'd1;
    end

    if (score_q == 8'hFF) begin
      score_inc_d = 8'hFF;
    end else begin
      score_inc_d = score_q + 8'd1;
    end

    if (gap_q >= GAP_W'(MIN_GAP + 2)) begin
      gap_dn_d = gap_q - GAP_W'(2);
    end else begin
      gap_dn_d = GAP_W'(MIN_GAP);
    end

    // Difficulty steps only on a real increment landing on a multiple of 8
    if ((score_q != 8'hFF) && (score_inc_d[2:0] == 3'd0)) begin
      gap_block_d = gap_dn_d;
    end else begin
      gap_block_d = gap_q;
    end

    // The exit cycle of SETTLE still contributes to the miss decision
    miss_d = miss_q | hit_player_in;
  end

  // Free-running LFSR; steps every clock regardless of game state
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Game sequencer: launch timing, flight supervision, scoring and lives
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      gap_q     <= GAP_W'(SPAWN_GAP);
      gap_cnt_q <= GAP_W'(SPAWN_GAP);
      fly_cnt_q <= '0;
      fly_age_q <= 2'd0;
      settle_q  <= 1'b0;
      miss_q    <= 1'b0;
      valid_q   <= 1'b0;
      dir_q     <= 2'd0;
      speed_q   <= 3'd1;
      inv_q     <= 1'b0;
      score_q   <= 8'd0;
      lives_q   <= 3'(LIVES);
      over_q    <= 1'b0;
`ifdef ARROW_FIXED_SEQ_EN
      seq_q     <= 2'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (start_in) begin
            gap_cnt_q <= gap_q;
            state_q   <= ST_GAP;
          end
        end

        ST_GAP: begin
          valid_q <= 1'b0;
          if (frame_tick) begin
            // Launch on the tick that brings the count to zero
            if (gap_cnt_q <= GAP_W'(1)) begin
              gap_cnt_q <= '0;
              dir_q     <= launch_dir_d;
              inv_q     <= launch_inv_d;
              speed_q   <= launch_speed_d;
              valid_q   <= 1'b1;
              fly_cnt_q <= '0;
              fly_age_q <= 2'd0;
`ifdef ARROW_FIXED_SEQ_EN
              seq_q     <= seq_q + 2'd1;
`endif
              state_q   <= ST_FLY;
            end else begin
              gap_cnt_q <= gap_cnt_q - GAP_W'(1);
            end
          end
        end

        ST_FLY: begin
          if (fly_age_q != 2'd2) begin
            fly_age_q <= fly_age_q + 2'd1;
          end
          // The arrow still shows its previous is_hit for two cycles after
          // launch; a resolution wins over a coincident timeout tick.
          if ((fly_age_q == 2'd2) && is_hit_in) begin
            miss_q   <= hit_player_in;
            settle_q <= 1'b0;
            state_q  <= ST_SETTLE;
          end else if (frame_tick) begin
            if (fly_cnt_q >= FLY_W'(FLY_MAX - 1)) begin
              valid_q   <= 1'b0;
              gap_cnt_q <= gap_q;
              state_q   <= ST_GAP;
            end else begin
              fly_cnt_q <= fly_cnt_q + FLY_W'(1);
            end
          end
        end

        ST_SETTLE: begin
          if (!settle_q) begin
            settle_q <= 1'b1;
            miss_q   <= miss_d;
          end else begin
            valid_q <= 1'b0;
            if (miss_d) begin
              lives_q <= lives_q - 3'd1;
              if (lives_q <= 3'd1) begin
                over_q  <= 1'b1;
                state_q <= ST_OVER;
              end else begin
                gap_cnt_q <= gap_q;
                state_q   <= ST_GAP;
              end
            end else begin
              score_q   <= score_inc_d;
              gap_q     <= gap_block_d;
              gap_cnt_q <= gap_block_d;
              state_q   <= ST_GAP;
            end
          end
        end

        ST_OVER: begin
          valid_q <= 1'b0;
          if (start_in) begin
            lives_q   <= 3'(LIVES);
            score_q   <= 8'd0;
            gap_q     <= GAP_W'(SPAWN_GAP);
            gap_cnt_q <= GAP_W'(SPAWN_GAP);
            over_q    <= 1'b0;
            state_q   <= ST_GAP;
          end
        end

        default: begin
          valid_q <= 1'b0;
          over_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign valid_out     = valid_q;
  assign direction_out = dir_q;
  assign speed_out     = speed_q;
  assign inversed_out  = inv_q;
  assign score_out     = score_q;
  assign lives_out     = lives_q;
  assign game_over_out = over_q;

endmodule

// File: tb/tb_arrow_spawner.sv
// -----------------------------------------------------------------------------
// tb_arrow_spawner
//
// Self-checking bench for arrow_spawner. Game-level reference: score, lives,
// gap and launch count are tracked per arrow from the game rules, gap length
// is measured in observed frame ticks, and launch attributes are predicted
// from a bench-side LFSR that steps with the clock.
// -----------------------------------------------------------------------------
module tb_arrow_spawner;

  localparam int          FR   = 2;        // clocks per raster frame
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        start_in;
  logic        is_hit;
  logic        hit_player;
  logic        valid_out;
  logic [1:0]  direction_out;
  logic [2:0]  speed_out;
  logic        inversed_out;
  logic [7:0]  score_out;
  logic [2:0]  lives_out;
  logic        game_over_out;

  arrow_spawner dut (
    .clk           (clk),
    .rst           (rst),
    .hcount_in     (hcount),
    .vcount_in     (vcount),
    .start_in      (start_in),
    .is_hit_in     (is_hit),
    .hit_player_in (hit_player),
    .valid_out     (valid_out),
    .direction_out (direction_out),
    .speed_out     (speed_out),
    .inversed_out  (inversed_out),
    .score_out     (score_out),
    .lives_out     (lives_out),
    .game_over_out (game_over_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          passed = 0;
  logic [15:0] lfsr_m;
  logic [15:0] lfsr_pre;
  int          ticks = 0;
  int          score_m = 0;
  int          lives_m = 3;
  int          gap_m = 60;
  int          launches_m = 0;
  bit          over_m = 1'b0;

  typedef struct {
    int delay;      // FLY cycles before is_hit (>= 2)
    bit hp;         // hit_player together with is_hit
    int late;       // 0 none, 1/2 = hit_player in SETTLE cycle 1/2
    int exp_score;
    int exp_lives;
    bit exp_over;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic finish_now();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  // One clock: count a tick if the DUT sees one, track the LFSR, advance raster
  task automatic clk1();
    if (hcount == 11'd0 && vcount == 10'd0) ticks++;
    lfsr_pre = lfsr_m;
    @(posedge clk);
    lfsr_m = rst ? SEED : lfsr_step(lfsr_m);
    #1;
    hcount = (hcount == 11'(FR - 1)) ? 11'd0 : hcount + 11'd1;
  endtask

  task automatic gap_noise();
    start_in   = 1'($urandom_range(0, 1));
    is_hit     = 1'($urandom_range(0, 1));
    hit_player = 1'($urandom_range(0, 1));
    vcount     = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 1023)) : 10'd0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, " valid"}, 32'(valid_out), 0);
    chk({nm, " dir"}, 32'(direction_out), 0);
    chk({nm, " speed"}, 32'(speed_out), 1);
    chk({nm, " inv"}, 32'(inversed_out), 0);
    chk({nm, " score"}, 32'(score_out), 0);
    chk({nm, " lives"}, 32'(lives_out), 3);
    chk({nm, " over"}, 32'(game_over_out), 0);
  endtask

  task automatic wait_launch(input string nm);
    int n;
    int exp_speed;
    logic [1:0] exp_dir;
    logic exp_inv;
    n = 0;
    while (valid_out !== 1'b1 && n < 4000) begin
      gap_noise();
      clk1();
      n++;
    end
    start_in = 1'b0; is_hit = 1'b0; hit_player = 1'b0; vcount = 10'd0;
    if (valid_out !== 1'b1) begin
      total++;
      $display("FAIL %s launch: valid_out=%b after %0d cycles, expected 1", nm, valid_out, n);
      finish_now();
    end
    chk({nm, " gap ticks"}, ticks, gap_m);
`ifdef ARROW_FIXED_SEQ_EN
    exp_dir = 2'(launches_m % 4);
    exp_inv = 1'b0;
`else
    exp_dir = lfsr_pre[1:0];
    exp_inv = lfsr_pre[2] & ~lfsr_pre[1];
`endif
    exp_speed = 1 + score_m / 8;
    if (exp_speed > 7) exp_speed = 7;
    chk({nm, " dir"}, 32'(direction_out), 32'(exp_dir));
    chk({nm, " inv"}, 32'(inversed_out), 32'(exp_inv));
    chk({nm, " speed"}, 32'(speed_out), exp_speed);
    launches_m++;
    ticks = 0;
  endtask

  // Called in FLY; resolves the arrow and checks the game-level outcome
  task automatic resolve(input string nm, input int delay, input bit hp, input int late);
    for (int i = 0; i < delay; i++) clk1();
    is_hit = 1'b1; hit_player = hp;
    clk1();
    is_hit = 1'b0; hit_player = (late == 1);
    chk({nm, " settle1 valid"}, 32'(valid_out), 1);
    clk1();
    hit_player = (late == 2);
    chk({nm, " settle2 valid"}, 32'(valid_out), 1);
    clk1();
    hit_player = 1'b0;
    ticks = 0;
    if (hp || late != 0) begin
      lives_m--;
      if (lives_m == 0) over_m = 1'b1;
    end else if (score_m < 255) begin
      score_m++;
      if (score_m % 8 == 0) gap_m = (gap_m - 2 < 20) ? 20 : gap_m - 2;
    end
    chk({nm, " valid after"}, 32'(valid_out), 0);
    chk({nm, " score"}, 32'(score_out), score_m);
    chk({nm, " lives"}, 32'(lives_out), lives_m);
    chk({nm, " over"}, 32'(game_over_out), 32'(over_m));
  endtask

  task automatic over_hold();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      hit_player = 1'(i % 2);
      is_hit = 1'(i % 3 == 0);
      clk1();
      if (valid_out !== 1'b0 || game_over_out !== 1'b1 || lives_out !== 3'd0) bad++;
    end
    is_hit = 1'b0; hit_player = 1'b0;
    chk("over hold bad cycles", bad, 0);
  endtask

  task automatic restart();
    start_in = 1'b1;
    clk1();
    start_in = 1'b0;
    ticks = 0;
    lives_m = 3; score_m = 0; gap_m = 60; over_m = 1'b0;
    chk("restart lives", 32'(lives_out), 3);
    chk("restart score", 32'(score_out), 0);
    chk("restart over", 32'(game_over_out), 0);
    chk("restart valid", 32'(valid_out), 0);
  endtask

  initial begin
    int n;
    int d;
    int m;

    vecs[0] = '{delay: 2, hp: 1'b0, late: 0, exp_score: 1, exp_lives: 3, exp_over: 1'b0};
    vecs[1] = '{delay: 3, hp: 1'b1, late: 0, exp_score: 1, exp_lives: 2, exp_over: 1'b0};
    vecs[2] = '{delay: 5, hp: 1'b0, late: 2, exp_score: 1, exp_lives: 1, exp_over: 1'b0};
    vecs[3] = '{delay: 2, hp: 1'b0, late: 0, exp_score: 2, exp_lives: 1, exp_over: 1'b0};
    vecs[4] = '{delay: 4, hp: 1'b0, late: 1, exp_score: 2, exp_lives: 0, exp_over: 1'b1};
    vecs[5] = '{delay: 2, hp: 1'b1, late: 0, exp_score: 0, exp_lives: 2, exp_over: 1'b0};

    rst = 1'b1; hcount = 11'd0; vcount = 10'd0;
    start_in = 1'b0; is_hit = 1'b0; hit_player = 1'b0;
    lfsr_m = SEED;
    repeat (3) clk1();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Idle ignores resolution noise
    hit_player = 1'b1; is_hit = 1'b1;
    repeat (4) clk1();
    hit_player = 1'b0; is_hit = 1'b0;
    chk("idle valid", 32'(valid_out), 0);

    // First launch: 60-tick gap, LFSR-derived attributes
    restart();
    wait_launch("first");

    // Table: blocks, misses at the hit cycle and during SETTLE, game over
    for (int i = 0; i < 5; i++) begin
      if (i != 0) wait_launch("tbl");
      resolve("tbl", vecs[i].delay, vecs[i].hp, vecs[i].late);
      chk("tbl vec score", 32'(score_out), vecs[i].exp_score);
      chk("tbl vec lives", 32'(lives_out), vecs[i].exp_lives);
      chk("tbl vec over", 32'(game_over_out), 32'(vecs[i].exp_over));
    end
    over_hold();
    restart();

    // Miss from a fresh game costs one life, score unchanged
    wait_launch("miss");
    resolve("miss", vecs[5].delay, vecs[5].hp, vecs[5].late);
    chk("miss vec lives", 32'(lives_out), vecs[5].exp_lives);
    chk("miss vec score", 32'(score_out), vecs[5].exp_score);

    // Stale is_hit during the first two FLY cycles is ignored
    wait_launch("stale");
    is_hit = 1'b1;
    clk1(); clk1();
    is_hit = 1'b0;
    repeat (4) clk1();
    chk("stale is_hit valid", 32'(valid_out), 1);
    resolve("stale", 0, 1'b0, 0);

    // Eight blocks from a fresh game shorten the gap to 58 and raise speed to 2
    over_m = 1'b0;
    start_in = 1'b0;
    lives_m = lives_m;
    for (int i = 0; i < 7; i++) begin
      wait_launch("blk8");
      resolve("blk8", 2, 1'b0, 0);
    end
    wait_launch("blk8 gap");
    chk("gap after 8 blocks", ticks == 0 ? 32'(speed_out) : 32'd0, 2);
    resolve("blk8", 2, 1'b0, 0);

    // Randomized games against the reference
    for (int k = 0; k < 30; k++) begin
      d = $urandom_range(2, 6);
      m = $urandom_range(0, 5);
      wait_launch("rnd");
      resolve("rnd", d, m == 0, (m == 1) ? 1 + (k % 2) : 0);
      if (over_m) begin
        over_hold();
        restart();
      end
    end

    // Flight timeout: 255 ticks without resolution, then relaunch
    wait_launch("timeout");
    n = 0;
    while (valid_out === 1'b1 && n < 2000) begin
      clk1();
      n++;
    end
    chk("timeout ticks", ticks, 255);
    chk("timeout score", 32'(score_out), score_m);
    chk("timeout lives", 32'(lives_out), lives_m);
    ticks = 0;
    wait_launch("relaunch");
    resolve("relaunch", 2, 1'b0, 0);

    // Block until score saturates, then one more block keeps it at 255
    n = 0;
    while (score_m < 255 && n < 300) begin
      wait_launch("sat");
      resolve("sat", 2, 1'b0, 0);
      n++;
    end
    wait_launch("sat top");
    chk("speed at top", 32'(speed_out), 7);
    resolve("sat top", 2, 1'b0, 0);
    chk("score saturated", 32'(score_out), 255);

    // Reset mid-flight returns every output to its reset value
    wait_launch("rst fly");
    clk1();
    rst = 1'b1;
    clk1();
    chk_reset_vals("rst fly");
    rst = 1'b0;
    score_m = 0; lives_m = 3; gap_m = 60; launches_m = 0; over_m = 1'b0;

    // Post-reset sequence restarts cleanly
    restart();
    for (int i = 0; i < 5; i++) begin
      wait_launch("post");
      resolve("post", 2 + i, 1'b0, 0);
    end

    finish_now();
  end

endmodule
